demux4_route: RTL and testbench

DEMUX4_ROUTE -- requirements
Module: demux4_route

---
 rtl/demux4_route.sv | 117 +++++++++++
 tb/tb_demux4_route.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_route.sv
// -----------------------------------------------------------------------------
// demux4_route
//   Routes an inbound word to one of four destinations. Each destination owns a
//   single-entry holding register (yN) with a valid flag (vldN). A held word
//   can be delivered and replaced on the same edge, so each destination can
//   sustain one word per cycle.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset (clears y, vld, occ)
//   d, s       : inbound word and destination select (0..3 -> y0..y3)
//   in_valid   : d/s are valid this cycle
//   in_ready   : combinational; the block takes d this cycle
//   y0..y3     : per-destination data registers
//   vld0..vld3 : matching yN holds an undelivered word
//   rdy0..rdy3 : destination N consumes yN this cycle
//   flush      : synchronous discard of every held word (y contents kept)
//   occ        : registered count of asserted vldN bits (0..4)
//
// Handshake: a word moves on a rising edge only when valid and ready are both
// high on that edge. The sender holds its data stable while valid is high and
// ready is low; ready never depends on the valid of the same interface.
// -----------------------------------------------------------------------------
module demux4_route #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             vld0,
  output logic             vld1,
  output logic             vld2,
  output logic             vld3,
  input  logic             rdy0,
  input  logic             rdy1,
  input  logic             rdy2,
  input  logic             rdy3,
  input  logic             flush,
  output logic [2:0]       occ
);

  logic [WIDTH-1:0] y_q [4];
  logic [3:0]       vld_q;
  logic [2:0]       occ_q;
  logic [3:0]       rdy_vec;
  logic [3:0]       load;
  logic [3:0]       deliver;
  logic [2:0]       dec_cnt;
  logic             accept;
  logic             inc;

  assign rdy_vec = {rdy3, rdy2, rdy1, rdy0};

  // A full destination can still accept when its current word leaves on the
  // same edge. rst_n gates ready so nothing is offered while reset is held.
  assign in_ready = rst_n & (~vld_q[s] | rdy_vec[s]) & ~flush;
  assign accept   = in_valid & in_ready;

  // Occupancy only grows when the word lands in an empty slot; a reload of a
  // slot that is delivering leaves the count unchanged.
  assign inc = accept & ~vld_q[s];

  always_comb begin
    load    = '0;
    deliver = '0;
    dec_cnt = '0;
    for (int n = 0; n < 4; n++) begin
      load[n]    = accept && (s == 2'(n));
      deliver[n] = vld_q[n] & rdy_vec[n];
      if (deliver[n] && !load[n]) begin
        dec_cnt = dec_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int n = 0; n < 4; n++) begin
        y_q[n] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any delivery or transfer; data registers keep contents.
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (load[n]) begin
          vld_q[n] <= 1'b1;
          y_q[n]   <= d;
        end else if (deliver[n]) begin
          vld_q[n] <= 1'b0;
        end
      end
      occ_q <= occ_q + {2'b00, inc} - dec_cnt;
    end
  end

  assign y0   = y_q[0];
  assign y1   = y_q[1];
  assign y2   = y_q[2];
  assign y3   = y_q[3];
  assign vld0 = vld_q[0];
  assign vld1 = vld_q[1];
  assign vld2 = vld_q[2];
  assign vld3 = vld_q[3];
  assign occ  = occ_q;

endmodule

// File: tb/tb_demux4_route.sv
// -----------------------------------------------------------------------------
// tb_demux4_route
//   Self-checking bench for demux4_route. The reference model is a queue of
//   undelivered words per destination plus the last word written to each y.
//   A negedge monitor pops a destination's queue whenever the DUT delivers.
// -----------------------------------------------------------------------------
module tb_demux4_route;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d;
  logic [1:0]   s;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y0, y1, y2, y3;
  logic         vld0, vld1, vld2, vld3;
  logic         rdy0, rdy1, rdy2, rdy3;
  logic         flush;
  logic [2:0]   occ;

  always #5 clk = ~clk;

  demux4_route #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .vld0     (vld0),
    .vld1     (vld1),
    .vld2     (vld2),
    .vld3     (vld3),
    .rdy0     (rdy0),
    .rdy1     (rdy1),
    .rdy2     (rdy2),
    .rdy3     (rdy3),
    .flush    (flush),
    .occ      (occ)
  );

  logic [3:0]   vld_vec;
  logic [3:0]   rdy_vec;
  logic [W-1:0] y_arr [4];
  assign vld_vec  = {vld3, vld2, vld1, vld0};
  assign rdy_vec  = {rdy3, rdy2, rdy1, rdy0};
  assign y_arr[0] = y0;
  assign y_arr[1] = y1;
  assign y_arr[2] = y2;
  assign y_arr[3] = y3;

  // ---------------- scoreboard / model ----------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] last_y [4];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      exp_q[n].delete();
      last_y[n] = '0;
    end
  endtask

  task automatic check_state();
    int total;
    total = 0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("vld%0d", n), W'(vld_vec[n]), W'(exp_q[n].size() != 0));
      check($sformatf("y%0d", n), y_arr[n], last_y[n]);
      total += exp_q[n].size();
    end
    check("occ", W'(occ), W'(total));
  endtask

  // Monitor: every delivery must hand out the oldest word owed to that slot.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      for (int n = 0; n < 4; n++) begin
        if (vld_vec[n] && rdy_vec[n]) begin
          if (exp_q[n].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver%0d: got word %0h, required no delivery", n, y_arr[n]);
          end else begin
            check($sformatf("deliver%0d", n), y_arr[n], exp_q[n].pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called shortly after a rising edge (or mid-cycle before a falling edge);
  // returns just after the next rising edge with the model updated.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [W-1:0] data,
                       input logic [3:0] rv, input logic fl, output logic rdy_obs);
    logic exp_rdy;
    in_valid = v;
    s        = sel;
    d        = data;
    {rdy3, rdy2, rdy1, rdy0} = rv;
    flush    = fl;
    @(negedge clk);
    #1;
    exp_rdy = rst_n && !fl && (exp_q[sel].size() == 0 || rv[sel]);
    rdy_obs = in_ready;
    check("in_ready", W'(in_ready), W'(exp_rdy));
    if (fl) begin
      for (int n = 0; n < 4; n++) exp_q[n].delete();
    end else if (v && exp_rdy) begin
      exp_q[sel].push_back(data);
      last_y[sel] = data;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    s        = '0;
    d        = '0;
    flush    = 1'b0;
    {rdy3, rdy2, rdy1, rdy0} = '0;
    model_reset();
    #2;
    check("rst_y0", y0, '0);
    check("rst_y3", y3, '0);
    check("rst_vld", W'(vld_vec), '0);
    check("rst_occ", W'(occ), '0);
    check("rst_in_ready", W'(in_ready), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // routing: fill all four destinations with no consumer
    cycle(1'b1, 2'd0, 32'hAAAA0000, 4'b0000, 1'b0, r);
    cycle(1'b1, 2'd1, 32'h1111, 4'b0000, 1'b0, r);
    cycle(1'b1, 2'd2, 32'h2222, 4'b0000, 1'b0, r);
    cycle(1'b1, 2'd3, 32'h3333, 4'b0000, 1'b0, r);
    check("route_occ", W'(occ), 32'd4);
    check("route_y0", y0, 32'hAAAA0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'(i), 32'hDEAD0000 + 32'(i), 4'b0000, 1'b0, r);
      check("route_full_ready", W'(r), '0);
    end

    // backpressure on destination 2
    cycle(1'b1, 2'd2, 32'h5, 4'b0000, 1'b0, r);
    check("bp_ready_low", W'(r), '0);
    check("bp_y2_hold", y2, 32'h2222);
    cycle(1'b1, 2'd2, 32'h5, 4'b0100, 1'b0, r);
    check("bp_ready_high", W'(r), 32'd1);
    check("bp_y2_new", y2, 32'h5);
    check("bp_vld2", W'(vld2), 32'd1);
    check("bp_occ", W'(occ), 32'd4);

    // simultaneous transfer to 0 and delivery on 3 from occ=2
    cycle(1'b0, 2'd0, '0, 4'b0011, 1'b0, r);
    check("sim_pre_occ", W'(occ), 32'd2);
    cycle(1'b1, 2'd0, 32'h77, 4'b1000, 1'b0, r);
    check("sim_ready", W'(r), 32'd1);
    check("sim_occ", W'(occ), 32'd2);
    check("sim_vld0", W'(vld0), 32'd1);
    check("sim_vld3", W'(vld3), '0);

    // flush from occ=3 with a competing transfer and delivery
    cycle(1'b1, 2'd1, 32'h88, 4'b0000, 1'b0, r);
    check("fl_pre_occ", W'(occ), 32'd3);
    cycle(1'b1, 2'd3, 32'h99, 4'b0001, 1'b1, r);
    check("fl_ready", W'(r), '0);
    check("fl_occ", W'(occ), '0);
    check("fl_y0", y0, 32'h77);
    check("fl_y1", y1, 32'h88);
    check("fl_y2", y2, 32'h5);
    check("fl_y3", y3, 32'h3333);

    // asynchronous reset mid-cycle with occ=4 and a transfer pending
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 32'hF0 + 32'(i), 4'b0000, 1'b0, r);
    check("ar_pre_occ", W'(occ), 32'd4);
    in_valid = 1'b1;
    s        = 2'd0;
    d        = 32'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld", W'(vld_vec), '0);
    check("ar_occ", W'(occ), '0);
    check("ar_y0", y0, '0);
    check("ar_y2", y2, '0);
    check("ar_in_ready", W'(in_ready), '0);
    model_reset();
    rst_n = 1'b1;
    cycle(1'b1, 2'd0, 32'hC0FFEE, 4'b0000, 1'b0, r);
    check("ar_first_accept", W'(r), 32'd1);
    check("ar_y0_new", y0, 32'hC0FFEE);

    // streaming into destination 1 with a permanent consumer
    cycle(1'b0, 2'd0, '0, 4'b0001, 1'b0, r);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 2'd1, 32'(i), 4'b0010, 1'b0, r);
      check("st_ready", W'(r), 32'd1);
      check("st_y1", y1, 32'(i));
      check("st_occ", W'(occ), 32'd1);
    end
    cycle(1'b0, 2'd1, '0, 4'b0010, 1'b0, r);
    check("st_drain_occ", W'(occ), '0);

    // randomized traffic
    repeat (400) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 15) == 0), r);
    end
    cycle(1'b0, 2'd0, '0, 4'b1111, 1'b0, r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
